// File: rtl/kmeans_pkg.sv
// Shared widths, FSM state encoding and error-bit indices for the CORE frame transmitter.
package kmeans_pkg;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 7;
  localparam int ERR_W  = 3;

  localparam int ERR_START   = 0;
  localparam int ERR_UNEXP   = 1;
  localparam int ERR_TIMEOUT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_RX = 2'd2,
    DONE_ST = 2'd3
  } state_t;
endpackage

// File: rtl/kmeans_frame_tx_if.sv
// Host push, frame control, CORE stream and result stream bundled for kmeans_frame_tx.
interface kmeans_frame_tx_if;
  import kmeans_pkg::*;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_full;
  logic [LEN_W-1:0]  fifo_count;
  logic              start;
  logic [LEN_W-1:0]  cfg_frame_len;
  logic [LEN_W-1:0]  cfg_out_len;
  logic              busy;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              done;
  logic [ERR_W-1:0]  err;

  modport slave (
    input  wr_en, wr_data, start, cfg_frame_len, cfg_out_len, out_valid, out_data,
    output wr_full, fifo_count, busy, in_valid, in_data, res_valid, res_data, done, err
  );

  modport master (
    output wr_en, wr_data, start, cfg_frame_len, cfg_out_len, out_valid, out_data,
    input  wr_full, fifo_count, busy, in_valid, in_data, res_valid, res_data, done, err
  );
endinterface

// File: rtl/kmeans_sync_fifo.sv
// Single-clock FIFO with registered read; the read register returns 0 on cycles without a pop
// so the consumer can use it directly as a zero-when-idle data bus.
module kmeans_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_rdata;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  // A push into a full buffer is legal only when the same cycle frees a slot.
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rdata <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_rdata <= w_pop ? r_mem[r_rptr] : '0;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_rdata;
  assign o_count = r_count;
endmodule

// File: rtl/kmeans_frame_tx.sv
// Frame transmitter: buffers host words, bursts one frame into CORE, then collects and
// forwards the expected number of response words, flagging protocol errors and timeouts.
module kmeans_frame_tx
  import kmeans_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 4096
) (
  input logic              clk,
  input logic              rst,
  kmeans_frame_tx_if.slave bus
);
  localparam int TO_W = $clog2(TIMEOUT) + 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LEN_W-1:0]  r_frame_len;
  logic [LEN_W-1:0]  r_out_len;
  logic [LEN_W-1:0]  r_tx_cnt;
  logic [LEN_W-1:0]  r_rx_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_in_valid;
  logic              r_res_valid;
  logic [DATA_W-1:0] r_res_data;
  logic              r_done;
  logic [ERR_W-1:0]  r_err;

  logic              w_start_ok;
  logic              w_start_bad;
  logic              w_pop;
  logic              w_rx;
  logic              w_rx_last;
  logic              w_tx_more;
  logic              w_timeout;
  logic [DATA_W-1:0] w_fifo_rdata;
  logic              w_full;
  logic              w_empty;
  logic [LEN_W-1:0]  w_count;

  kmeans_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (LEN_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.wr_en),
    .i_wdata (bus.wr_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    w_pop       = 1'b0;
    w_rx        = 1'b0;
    w_timeout   = 1'b0;
    w_tx_more   = (r_tx_cnt < r_frame_len);
    w_rx_last   = ((r_rx_cnt + LEN_W'(1)) == r_out_len);
    case (r_state)
      IDLE: begin
        // The first word is popped on the accepting edge so in_valid rises the next cycle.
        if (bus.start) begin
          if ((bus.cfg_frame_len != '0) && (bus.cfg_frame_len <= w_count)) begin
            w_start_ok  = 1'b1;
            w_pop       = 1'b1;
            w_state_nxt = SEND;
          end else begin
            w_start_bad = 1'b1;
          end
        end
      end
      SEND: begin
        if (w_tx_more && !w_empty) w_pop = 1'b1;
        else w_state_nxt = (r_out_len == '0) ? DONE_ST : WAIT_RX;
      end
      WAIT_RX: begin
        if (bus.out_valid) begin
          w_rx = 1'b1;
          if (w_rx_last) w_state_nxt = DONE_ST;
        end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      DONE_ST: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_frame_len <= '0;
      r_out_len   <= '0;
      r_tx_cnt    <= '0;
      r_rx_cnt    <= '0;
      r_to_cnt    <= '0;
      r_in_valid  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_done      <= 1'b0;
      r_err       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_valid  <= w_pop;
      r_res_valid <= w_rx;
      r_res_data  <= w_rx ? bus.out_data : '0;
      r_done      <= (r_state == DONE_ST);
      r_err[ERR_START]   <= w_start_bad;
      r_err[ERR_UNEXP]   <= bus.out_valid && (r_state != WAIT_RX);
      r_err[ERR_TIMEOUT] <= w_timeout;
      if (w_start_ok) begin
        r_frame_len <= bus.cfg_frame_len;
        r_out_len   <= bus.cfg_out_len;
        r_tx_cnt    <= LEN_W'(1);
        r_rx_cnt    <= '0;
      end else if (w_pop) begin
        r_tx_cnt <= r_tx_cnt + LEN_W'(1);
      end
      if (w_rx) r_rx_cnt <= r_rx_cnt + LEN_W'(1);
      // Idle-response counter only runs while waiting and restarts on every response word.
      if ((r_state != WAIT_RX) || bus.out_valid) r_to_cnt <= '0;
      else r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign bus.wr_full    = w_full;
  assign bus.fifo_count = w_count;
  assign bus.busy       = (r_state == SEND) || (r_state == WAIT_RX);
  assign bus.in_valid   = r_in_valid;
  assign bus.in_data    = w_fifo_rdata;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_data   = r_res_data;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_kmeans_frame_tx.sv
// Directed bench for kmeans_frame_tx: hand-computed expectations, one linear stimulus sequence.
module tb_kmeans_frame_tx;
  import kmeans_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  kmeans_frame_tx_if bus ();

  kmeans_frame_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    bus.wr_en   = 1'b1;
    bus.wr_data = w;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic start_frame(input int flen, input int olen);
    bus.start         = 1'b1;
    bus.cfg_frame_len = 7'(flen);
    bus.cfg_out_len   = 7'(olen);
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.wr_en = 0; bus.wr_data = '0; bus.start = 0;
    bus.cfg_frame_len = '0; bus.cfg_out_len = '0;
    bus.out_valid = 0; bus.out_data = '0;
    rst = 1'b1;
    step(); step(); step();
    chk("rst_flags", {bus.in_valid, bus.res_valid, bus.done, bus.busy, bus.wr_full, bus.err}, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_data", {bus.in_data, bus.res_data}, 0);
    rst = 1'b0;
    step();

    // 1: basic frame of 8 with two responses
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    chk("t1_count", bus.fifo_count, 8);
    start_frame(8, 2);
    chk("t1_busy", bus.busy, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("t1_in_valid", bus.in_valid, 1);
      chk("t1_in_data", bus.in_data, i);
      step();
    end
    chk("t1_in_valid_end", bus.in_valid, 0);
    chk("t1_in_data_end", bus.in_data, 0);
    chk("t1_busy_wait", bus.busy, 1);
    bus.out_valid = 1'b1; bus.out_data = 16'hA5A5;
    step();
    chk("t1_res0_valid", bus.res_valid, 1);
    chk("t1_res0_data", bus.res_data, 16'hA5A5);
    bus.out_data = 16'h5A5A;
    step();
    bus.out_valid = 1'b0; bus.out_data = '0;
    chk("t1_res1_valid", bus.res_valid, 1);
    chk("t1_res1_data", bus.res_data, 16'h5A5A);
    chk("t1_done_early", bus.done, 0);
    step();
    chk("t1_done", bus.done, 1);
    chk("t1_res_idle", {bus.res_valid, bus.res_data}, 0);
    chk("t1_err_none", bus.err, 0);
    step();
    chk("t1_done_pulse", bus.done, 0);
    chk("t1_busy_idle", bus.busy, 0);

    // 2: bad starts
    push_word(16'h0011); push_word(16'h0022); push_word(16'h0033);
    start_frame(4, 0);
    chk("t2_err_len", bus.err, 3'b001);
    chk("t2_no_send", {bus.in_valid, bus.busy}, 0);
    step();
    chk("t2_err_pulse", bus.err, 0);
    chk("t2_count", bus.fifo_count, 3);
    start_frame(0, 0);
    chk("t2_err_zero", bus.err, 3'b001);
    step();

    // 4: stray response in IDLE, then response timeout
    bus.out_valid = 1'b1; bus.out_data = 16'h1234;
    step();
    bus.out_valid = 1'b0; bus.out_data = '0;
    chk("t4_err_unexp", bus.err, 3'b010);
    chk("t4_no_res", bus.res_valid, 0);
    step();
    start_frame(3, 1);
    chk("t4_w0", bus.in_data, 16'h0011); step();
    chk("t4_w1", bus.in_data, 16'h0022); step();
    chk("t4_w2", bus.in_data, 16'h0033); step();
    chk("t4_wait_busy", bus.busy, 1);
    n = 1;
    while (bus.err[ERR_TIMEOUT] !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    chk("t4_timeout_cycles", n, 4097);
    chk("t4_err_timeout", bus.err, 3'b100);
    chk("t4_busy_off", bus.busy, 0);
    chk("t4_no_done", bus.done, 0);
    step();

    // 3: full buffer, overflow drop, push/pop at full
    for (int i = 0; i < 64; i++) push_word(16'(16'h0100 + i));
    chk("t3_full", bus.wr_full, 1);
    chk("t3_count64", bus.fifo_count, 64);
    push_word(16'hDEAD);
    chk("t3_drop", bus.fifo_count, 64);
    bus.wr_en = 1'b1; bus.wr_data = 16'hBEEF;
    start_frame(64, 0);
    for (int i = 0; i < 64; i++) begin
      if (i == 63) bus.wr_en = 1'b0;
      chk("t3_in_valid", bus.in_valid, 1);
      chk("t3_in_data", bus.in_data, 16'h0100 + i);
      step();
    end
    chk("t3_count_after", bus.fifo_count, 64);
    chk("t3_valid_end", bus.in_valid, 0);
    step();
    chk("t3_done", bus.done, 1);
    step();
    start_frame(64, 0);
    for (int i = 0; i < 64; i++) begin
      chk("t3_beef", {bus.in_valid, bus.in_data}, {1'b1, 16'hBEEF});
      step();
    end
    chk("t3_empty", bus.fifo_count, 0);
    step();
    chk("t3_done2", bus.done, 1);
    step();

    // 5: start while busy ignored, reset mid-SEND
    for (int i = 1; i <= 8; i++) push_word(16'(16'h0050 + i));
    start_frame(8, 1);
    chk("t5_w0", bus.in_data, 16'h0051);
    step();
    start_frame(2, 0);
    chk("t5_busy_start", bus.err, 0);
    chk("t5_w2", {bus.in_valid, bus.in_data}, {1'b1, 16'h0053});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_flags", {bus.in_valid, bus.res_valid, bus.done, bus.busy, bus.wr_full, bus.err}, 0);
    chk("t5_rst_data", {bus.in_data, bus.res_data}, 0);
    chk("t5_rst_count", bus.fifo_count, 0);
    step();
    chk("t5_quiet", {bus.in_valid, bus.done, bus.err}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
